// File: rtl/cpu_bank_reg_wb_arbiter.sv
// Writeback arbiter for the CPU register bank.
// Round-robin grants one of NUM_REQ requesters onto the single bank write
// port through a registered stage, and tracks a per-register pending-write
// scoreboard for read-after-write hazard detection on two read ports.
module cpu_bank_reg_wb_arbiter #(
    parameter int unsigned NUM_REQ    = 2,
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned DATA_W     = 32
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*REG_ADDR_W-1:0] req_reg,
    input  logic [NUM_REQ*DATA_W-1:0]     req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          write_enable,
    output logic [REG_ADDR_W-1:0]         write_reg,
    output logic [DATA_W-1:0]             write_data,
    input  logic                          reserve_valid,
    input  logic [REG_ADDR_W-1:0]         reserve_reg,
    input  logic [REG_ADDR_W-1:0]         query_reg_a,
    input  logic [REG_ADDR_W-1:0]         query_reg_b,
    output logic                          busy_a,
    output logic                          busy_b
);

    localparam int unsigned PTR_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned NUM_REGS = 1 << REG_ADDR_W;

    logic [PTR_W-1:0]      ptr_q, ptr_d;
    logic                  we_q, we_d;
    logic [REG_ADDR_W-1:0] wreg_q, wreg_d;
    logic [DATA_W-1:0]     wdata_q, wdata_d;
    logic [NUM_REGS-1:0]   busy_q, busy_d;

    logic [NUM_REQ-1:0]    grant;
    logic [PTR_W-1:0]      gnt_idx;
    logic                  gnt_any;

    logic [REG_ADDR_W-1:0] reg_arr  [NUM_REQ];
    logic [DATA_W-1:0]     data_arr [NUM_REQ];

    // Unpack the flat requester buses into per-requester arrays.
    genvar gi;
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
        assign reg_arr[gi]  = req_reg[gi*REG_ADDR_W +: REG_ADDR_W];
        assign data_arr[gi] = req_data[gi*DATA_W +: DATA_W];
    end

    // Round-robin search starting at the pointer, wrapping modulo NUM_REQ.
    always_comb begin
        int unsigned      cand;
        logic [PTR_W-1:0] cand_w;
        grant   = '0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        cand    = 0;
        cand_w  = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            cand = 32'(ptr_q) + k;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            cand_w = PTR_W'(cand);
            if (!gnt_any && req_valid[cand_w]) begin
                grant[cand_w] = 1'b1;
                gnt_idx       = cand_w;
                gnt_any       = 1'b1;
            end
        end
    end

    assign req_ready = grant;

    // Next pointer, captured write stage and scoreboard update.
    always_comb begin
        ptr_d   = ptr_q;
        we_d    = 1'b0;
        wreg_d  = wreg_q;
        wdata_d = wdata_q;
        busy_d  = busy_q;
        if (gnt_any) begin
            ptr_d   = (gnt_idx == PTR_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
            we_d    = 1'b1;
            wreg_d  = reg_arr[gnt_idx];
            wdata_d = data_arr[gnt_idx];
        end
        // Clear first so a same-cycle reservation of the retiring register wins.
        if (we_q) begin
            busy_d[wreg_q] = 1'b0;
        end
        if (reserve_valid) begin
            busy_d[reserve_reg] = 1'b1;
        end
    end

    // State registers; reset drops any captured write and clears the scoreboard.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ptr_q   <= '0;
            we_q    <= 1'b0;
            wreg_q  <= '0;
            wdata_q <= '0;
            busy_q  <= '0;
        end else begin
            ptr_q   <= ptr_d;
            we_q    <= we_d;
            wreg_q  <= wreg_d;
            wdata_q <= wdata_d;
            busy_q  <= busy_d;
        end
    end

    assign write_enable = we_q;
    assign write_reg    = wreg_q;
    assign write_data   = wdata_q;
    assign busy_a       = busy_q[query_reg_a];
    assign busy_b       = busy_q[query_reg_b];

endmodule
